// File: rtl/adder_inverse_serial.sv
// Digit-serial inverse of a 16-bit ripple-carry adder: recovers A = {cout, sum} - B - cin,
// DIGIT bits per cycle, LSB digit first, with valid/ready handshakes on both sides.
`timescale 1ns/1ps
module adder_inverse_serial #(
  parameter int DIGIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sum,
  input  logic        in_cout,
  input  logic [15:0] in_b,
  input  logic        in_cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_a,
  output logic        out_err
);

  localparam int         N    = 16 / DIGIT;
  localparam logic [4:0] LAST = 5'(N - 1);

  generate
    if (DIGIT != 1 && DIGIT != 2 && DIGIT != 4 && DIGIT != 8 && DIGIT != 16) begin : g_bad_digit
      $error("adder_inverse_serial: DIGIT must be one of 1, 2, 4, 8, 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] sum_reg, b_reg, a_reg;
  logic        cout_reg, borrow_reg, err_reg;
  logic [4:0]  cnt_reg;

  logic             accept, last_step;
  logic [DIGIT:0]   diff;
  logic [15:0]      sum_shift, b_shift, a_shift;

  assign accept    = (state_reg == IDLE) && in_valid;
  assign last_step = (state_reg == RUN) && (cnt_reg == LAST);

  // One digit of subtraction; the extra top bit is the digit borrow-out.
  assign diff = {1'b0, sum_reg[DIGIT-1:0]} - {1'b0, b_reg[DIGIT-1:0]} - (DIGIT+1)'(borrow_reg);

  generate
    if (DIGIT == 16) begin : g_full
      assign sum_shift = '0;
      assign b_shift   = '0;
      assign a_shift   = diff[15:0];
    end else begin : g_part
      assign sum_shift = {{DIGIT{1'b0}}, sum_reg[15:DIGIT]};
      assign b_shift   = {{DIGIT{1'b0}}, b_reg[15:DIGIT]};
      assign a_shift   = {diff[DIGIT-1:0], a_reg[15:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg    <= '0;
      b_reg      <= '0;
      a_reg      <= '0;
      cout_reg   <= 1'b0;
      borrow_reg <= 1'b0;
      err_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      sum_reg    <= in_sum;
      b_reg      <= in_b;
      cout_reg   <= in_cout;
      borrow_reg <= in_cin;
      cnt_reg    <= '0;
    end else if (state_reg == RUN) begin
      sum_reg    <= sum_shift;
      b_reg      <= b_shift;
      a_reg      <= a_shift;
      borrow_reg <= diff[DIGIT];
      cnt_reg    <= cnt_reg + 5'd1;
      // Out of range exactly when carry-out and final borrow disagree.
      if (last_step) err_reg <= cout_reg ^ diff[DIGIT];
    end
  end

  assign out_a   = a_reg;
  assign out_err = err_reg;

endmodule

// File: tb/tb_adder_inverse_serial.sv
// Bench for adder_inverse_serial: one instance per legal DIGIT, directed cases plus
// randomized requests checked against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_adder_inverse_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  in_valid = '0;
  logic [4:0]  out_ready = '0;
  logic [4:0]  in_ready, out_valid, out_err;
  logic [15:0] out_a [5];
  logic [15:0] in_sum = '0, in_b = '0;
  logic        in_cout = 1'b0, in_cin = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    adder_inverse_serial #(.DIGIT(1 << gi)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[gi]),
      .in_ready (in_ready[gi]),
      .in_sum   (in_sum),
      .in_cout  (in_cout),
      .in_b     (in_b),
      .in_cin   (in_cin),
      .out_valid(out_valid[gi]),
      .out_ready(out_ready[gi]),
      .out_a    (out_a[gi]),
      .out_err  (out_err[gi])
    );
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the 17-bit adder result.
  function automatic void model(input logic [15:0] s, input logic c, input logic [15:0] b,
                                input logic ci, output logic [15:0] a, output logic e);
    int v;
    v = int'({c, s}) - int'(b) - int'(ci);
    a = v[15:0];
    e = (v < 0) || (v > 65535);
  endfunction

  task automatic run_req(input int idx, input logic [15:0] s, input logic c, input logic [15:0] b,
                         input logic ci, output logic [15:0] a, output logic e, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready[idx] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", 32'(in_ready[idx]), 32'd1);
    in_sum = s; in_cout = c; in_b = b; in_cin = ci;
    in_valid[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    // Scramble request inputs: they must be ignored after the accept edge.
    in_sum = 16'($urandom); in_b = 16'($urandom);
    in_cout = 1'($urandom); in_cin = 1'($urandom);
    lat = 0;
    while (!out_valid[idx] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    a = out_a[idx];
    e = out_err[idx];
  endtask

  task automatic release_out(input int idx);
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
    check("in_ready_after_release", 32'(in_ready[idx]), 32'd1);
    check("out_valid_after_release", 32'(out_valid[idx]), 32'd0);
  endtask

  task automatic directed(input string name, input logic [15:0] s, input logic c,
                          input logic [15:0] b, input logic ci);
    logic [15:0] a, ea;
    logic        e, ee;
    int          lat;
    model(s, c, b, ci, ea, ee);
    run_req(2, s, c, b, ci, a, e, lat);
    $display("%s: sum=%04h cout=%0d b=%04h cin=%0d -> a=%04h err=%0d lat=%0d", name, s, c, b, ci, a, e, lat);
    check({name, "_a"}, 32'(a), 32'(ea));
    check({name, "_err"}, 32'(e), 32'(ee));
    check({name, "_lat"}, 32'(lat), 32'd4);
    release_out(2);
  endtask

  initial begin
    logic [15:0] a, s, b, ea, va;
    logic        e, c, ci, ee;
    int          lat;
    logic        seen;
    logic [16:0] tot;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_a", 32'(out_a[2]), 32'd0);
    check("reset_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'h1f);

    // Spec reference values, held as constants rather than recomputed.
    directed("basic", 16'h1234, 1'b0, 16'h0234, 1'b0);
    model(16'h1234, 1'b0, 16'h0234, 1'b0, ea, ee);
    check("basic_const_a", 32'(ea), 32'h1000);
    directed("carry_wrap", 16'h0000, 1'b1, 16'hFFFF, 1'b1);
    directed("overflow", 16'hFFFF, 1'b1, 16'h0000, 1'b0);
    model(16'hFFFF, 1'b1, 16'h0000, 1'b0, ea, ee);
    check("overflow_const_err", 32'(ee), 32'd1);
    directed("underflow", 16'h0000, 1'b0, 16'h0001, 1'b0);
    model(16'h0000, 1'b0, 16'h0001, 1'b0, ea, ee);
    check("underflow_const_a", 32'(ea), 32'hFFFF);

    // Backpressure with a rejected second request
    model(16'hBEEF, 1'b0, 16'h1111, 1'b1, ea, ee);
    run_req(2, 16'hBEEF, 1'b0, 16'h1111, 1'b1, a, e, lat);
    $display("backpressure: a=%04h err=%0d lat=%0d", a, e, lat);
    check("bp_first_a", 32'(a), 32'(ea));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        in_sum = 16'h0F0F; in_b = 16'h0001; in_valid[2] = 1'b1;
      end else begin
        in_valid[2] = 1'b0;
      end
      check("bp_out_valid", 32'(out_valid[2]), 32'd1);
      check("bp_in_ready", 32'(in_ready[2]), 32'd0);
      check("bp_out_a", 32'(out_a[2]), 32'(ea));
      check("bp_out_err", 32'(out_err[2]), 32'(ee));
    end
    @(negedge clk);
    in_valid[2] = 1'b0;
    check("bp_after_pulse_a", 32'(out_a[2]), 32'(ea));
    release_out(2);

    // Reset during RUN, step 2
    @(negedge clk);
    in_sum = 16'hA5A5; in_cout = 1'b1; in_b = 16'h1234; in_cin = 1'b0; in_valid[2] = 1'b1;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid[2]), 32'd0);
    check("rst_mid_out_a", 32'(out_a[2]), 32'd0);
    check("rst_mid_out_err", 32'(out_err[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", 32'(in_ready[2]), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid[2] || !in_ready[2]) seen = 1'b1;
    end
    $display("reset_mid_run: stale activity=%0d", seen);
    check("rst_no_stale_result", 32'(seen), 32'd0);

    // Sweep: every DIGIT, add-generated inverses then arbitrary inputs
    for (int idx = 0; idx < 5; idx++) begin
      for (int t = 0; t < 300; t++) begin
        if (t < 250) begin
          va  = 16'($urandom);
          b   = 16'($urandom);
          ci  = 1'($urandom);
          tot = 17'(va) + 17'(b) + 17'(ci);
          s   = tot[15:0];
          c   = tot[16];
          ea  = va;
          ee  = 1'b0;
        end else begin
          s  = 16'($urandom);
          b  = 16'($urandom);
          c  = 1'($urandom);
          ci = 1'($urandom);
          model(s, c, b, ci, ea, ee);
        end
        run_req(idx, s, c, b, ci, a, e, lat);
        $display("digit=%0d t=%0d sum=%04h cout=%0d b=%04h cin=%0d -> a=%04h err=%0d lat=%0d",
                 1 << idx, t, s, c, b, ci, a, e, lat);
        check("sweep_a", 32'(a), 32'(ea));
        check("sweep_err", 32'(e), 32'(ee));
        check("sweep_lat", 32'(lat), 32'(16 >> idx));
        release_out(idx);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
